// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter: registered one-hot grant gates each requester bus to zero when not owned.
// Optional preemption under contention after MAX_HOLD cycles is enabled with `define ARB_TIMEOUT_EN.
module rr_bus_arbiter #(
  parameter int unsigned BUS_WIDTH = 4,
  parameter int unsigned NB_INS    = 3,
  parameter int unsigned MAX_HOLD  = 8,
  localparam int unsigned IDX_W    = (NB_INS > 1) ? $clog2(NB_INS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NB_INS-1:0]    req,
  input  logic [BUS_WIDTH-1:0] in_buses    [NB_INS],
  output logic [BUS_WIDTH-1:0] gated_buses [NB_INS],
  output logic [NB_INS-1:0]    grant,
  output logic [IDX_W-1:0]     owner,
  output logic                 busy
);

  if (NB_INS < 2 || MAX_HOLD < 1) begin : gen_param_check
    $error("rr_bus_arbiter: NB_INS must be >= 2 and MAX_HOLD >= 1");
  end

  typedef enum logic [0:0] {StIdle, StGranted} state_e;

  state_e              state_q, state_d;
  logic [NB_INS-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [NB_INS-1:0]   cand;
  logic [NB_INS-1:0]   pick_onehot;
  logic [IDX_W-1:0]    pick;
  logic                found;
  logic                new_grant;
  logic                timeout;

  // Search starts after the most recent owner; the current owner is masked so it
  // can never re-win its own handoff or preemption.
  always_comb begin
    int unsigned idx;
    cand        = req & ~grant_q;
    found       = 1'b0;
    pick        = '0;
    pick_onehot = '0;
    idx         = 0;
    for (int unsigned k = 0; k < NB_INS; k++) begin
      idx = (32'(last_q) + 32'd1 + k) % NB_INS;
      if (!found && cand[idx]) begin
        found            = 1'b1;
        pick             = IDX_W'(idx);
        pick_onehot[idx] = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [HOLD_W-1:0] hold_q, hold_d;

  assign timeout = (hold_q == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    hold_d = hold_q;
    if (new_grant || state_d == StIdle) begin
      hold_d = '0;
    end else if (!timeout) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    new_grant = 1'b0;
    unique case (state_q)
      StIdle: begin
        new_grant = found;
      end
      StGranted: begin
        if (!req[owner_q]) begin
          new_grant = found;
          if (!found) begin
            state_d = StIdle;
            grant_d = '0;
            owner_d = '0;
          end
        end else if (timeout && found) begin
          new_grant = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        owner_d = '0;
      end
    endcase
    if (new_grant) begin
      state_d = StGranted;
      grant_d = pick_onehot;
      owner_d = pick;
    end
  end

  assign last_d = new_grant ? pick : last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(NB_INS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NB_INS; i++) begin
      gated_buses[i] = grant_q[i] ? in_buses[i] : '0;
    end
  end

  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = |grant_q;

endmodule
